// File: rtl/common_ip_pkg.sv
// Shared definitions for the pulse handshake responder: state encoding,
// drop counter ceiling and the drop counter update rule.
package common_ip_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ACKH = 2'd2
  } hs_state_e;

  localparam logic [7:0] DROP_CNT_MAX = 8'd255;

  // Next drop counter value; a new drop outranks a clear in the same cycle.
  function automatic logic [7:0] drop_cnt_next(input logic [7:0] cur,
                                               input logic       drop,
                                               input logic       clr);
    logic [7:0] nxt;
    if (drop) begin
      if (clr) begin
        nxt = 8'd1;
      end else if (cur == DROP_CNT_MAX) begin
        nxt = DROP_CNT_MAX;
      end else begin
        nxt = cur + 8'd1;
      end
    end else if (clr) begin
      nxt = 8'd0;
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pulse_handshake_rsp_sync.sv
// Multi-stage level synchronizer with asynchronous active-low reset.
// The output is the last flop of a SYNC_STEP-deep shift chain.
module jlsemi_util_sync_pos_with_rst_low #(
  parameter int SYNC_STEP = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STEP-1:0] sync_r;

  // Shift the asynchronous input through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STEP{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STEP-2:0], d};
    end
  end

  assign q = sync_r[SYNC_STEP-1];

endmodule

// File: rtl/pulse_handshake_rsp.sv
// Responder side of a 4-phase level request/acknowledge handshake.
// A synchronized request captures the payload into a local event; the event
// completes on evt_ready or is dropped on timeout, after which ack is raised
// and held until the remote withdraws its request.
module pulse_handshake_rsp
  import common_ip_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int SYNC_STEP = 2,
  parameter int TO_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_async,
  input  logic [DATA_W-1:0] req_data,
  output logic              ack,
  output logic              evt_valid,
  output logic [DATA_W-1:0] evt_data,
  input  logic              evt_ready,
  input  logic [TO_W-1:0]   timeout_cfg,
  output logic              timeout_err,
  input  logic              err_clr,
  output logic [7:0]        drop_cnt,
  output logic              busy
);

  localparam logic [TO_W-1:0]   CNT_ZERO  = {TO_W{1'b0}};
  localparam logic [TO_W-1:0]   CNT_ONE   = TO_W'(1'b1);
  localparam logic [TO_W-1:0]   CNT_MAX   = {TO_W{1'b1}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  hs_state_e         state_r;
  logic [TO_W-1:0]   cnt_r;
  logic              ack_r;
  logic              evt_valid_r;
  logic [DATA_W-1:0] evt_data_r;
  logic              busy_r;
  logic              timeout_err_r;
  logic [7:0]        drop_cnt_r;

  logic              req_s;
  logic [TO_W-1:0]   cfg_last_s;
  logic [TO_W-1:0]   cnt_inc_s;
  logic              timeout_hit_s;

  jlsemi_util_sync_pos_with_rst_low #(
    .SYNC_STEP (SYNC_STEP)
  ) u_req_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (req_async),
    .q     (req_s)
  );

  // The timeout compares against the live configuration so a change during
  // PEND applies at once; evt_ready masks the timeout so a completing
  // consumer always wins the tie.
  assign cfg_last_s    = timeout_cfg - CNT_ONE;
  assign cnt_inc_s     = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);
  assign timeout_hit_s = (state_r == ST_PEND) && !evt_ready &&
                         (timeout_cfg != CNT_ZERO) && (cnt_r == cfg_last_s);

  // Handshake FSM with registered ack, event valid, payload, busy and PEND counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      ack_r       <= 1'b0;
      evt_valid_r <= 1'b0;
      evt_data_r  <= DATA_ZERO;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_s) begin
            state_r     <= ST_PEND;
            evt_data_r  <= req_data;
            evt_valid_r <= 1'b1;
            busy_r      <= 1'b1;
            cnt_r       <= CNT_ZERO;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_PEND: begin
          if (evt_ready || timeout_hit_s) begin
            state_r     <= ST_ACKH;
            evt_valid_r <= 1'b0;
            ack_r       <= 1'b1;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        ST_ACKH: begin
          if (!req_s) begin
            state_r <= ST_IDLE;
            ack_r   <= 1'b0;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_ACKH;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cnt_r       <= CNT_ZERO;
          ack_r       <= 1'b0;
          evt_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // Sticky timeout flag and saturating drop counter; a new drop beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err_r <= 1'b0;
      drop_cnt_r    <= 8'd0;
    end else begin
      if (timeout_hit_s) begin
        timeout_err_r <= 1'b1;
      end else if (err_clr) begin
        timeout_err_r <= 1'b0;
      end else begin
        timeout_err_r <= timeout_err_r;
      end
      drop_cnt_r <= drop_cnt_next(drop_cnt_r, timeout_hit_s, err_clr);
    end
  end

  assign ack         = ack_r;
  assign evt_valid   = evt_valid_r;
  assign evt_data    = evt_data_r;
  assign busy        = busy_r;
  assign timeout_err = timeout_err_r;
  assign drop_cnt    = drop_cnt_r;

endmodule

// File: tb/tb_pulse_handshake_rsp.sv
// Directed self-checking bench for pulse_handshake_rsp (default parameters).
module tb_pulse_handshake_rsp;

  logic        clk;
  logic        rst_n;
  logic        req_async;
  logic [31:0] req_data;
  logic        ack;
  logic        evt_valid;
  logic [31:0] evt_data;
  logic        evt_ready;
  logic [15:0] timeout_cfg;
  logic        timeout_err;
  logic        err_clr;
  logic [7:0]  drop_cnt;
  logic        busy;

  int n_pass;
  int n_total;

  pulse_handshake_rsp dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_async   (req_async),
    .req_data    (req_data),
    .ack         (ack),
    .evt_valid   (evt_valid),
    .evt_data    (evt_data),
    .evt_ready   (evt_ready),
    .timeout_cfg (timeout_cfg),
    .timeout_err (timeout_err),
    .err_clr     (err_clr),
    .drop_cnt    (drop_cnt),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raise the request; after three edges the event is pending.
  task automatic req_start(input logic [31:0] d);
    req_data  = d;
    req_async = 1'b1;
    step(3);
  endtask

  // Drop the request; after three edges the block is back in IDLE.
  task automatic req_end();
    req_async = 1'b0;
    step(3);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(2);
    n_total++; if (ack !== 1'b0) $display("FAIL reset_ack: got %b exp 0", ack); else n_pass++;
    n_total++; if (evt_valid !== 1'b0) $display("FAIL reset_valid: got %b exp 0", evt_valid); else n_pass++;
    n_total++; if (evt_data !== 32'h0) $display("FAIL reset_data: got %h exp 0", evt_data); else n_pass++;
    n_total++; if ({timeout_err, drop_cnt, busy} !== 10'h0) $display("FAIL reset_err_cnt_busy: got %b/%0d/%b exp 0/0/0", timeout_err, drop_cnt, busy); else n_pass++;
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_basic();
    evt_ready   = 1'b1;
    timeout_cfg = 16'd0;
    req_data    = 32'hA5A5_0001;
    req_async   = 1'b1;
    step(2);
    n_total++; if (evt_valid !== 1'b0) $display("FAIL basic_early_valid: got %b exp 0 at edge 2", evt_valid); else n_pass++;
    step(1);
    n_total++; if (evt_valid !== 1'b1) $display("FAIL basic_valid_edge3: got %b exp 1", evt_valid); else n_pass++;
    n_total++; if (evt_data !== 32'hA5A5_0001) $display("FAIL basic_data: got %h exp a5a50001", evt_data); else n_pass++;
    n_total++; if ({busy, ack} !== 2'b10) $display("FAIL basic_busy_ack_pend: got %b%b exp 10", busy, ack); else n_pass++;
    step(1);
    n_total++; if ({evt_valid, ack} !== 2'b01) $display("FAIL basic_ack_rise: got valid=%b ack=%b exp 0/1", evt_valid, ack); else n_pass++;
    req_async = 1'b0;
    step(2);
    n_total++; if (ack !== 1'b1) $display("FAIL basic_ack_hold: got %b exp 1 two edges after drop", ack); else n_pass++;
    step(1);
    n_total++; if ({ack, busy} !== 2'b00) $display("FAIL basic_ack_fall: got ack=%b busy=%b exp 0/0", ack, busy); else n_pass++;
  endtask

  task automatic test_backpressure();
    evt_ready   = 1'b0;
    timeout_cfg = 16'd0;
    req_start(32'h1234_5678);
    req_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      n_total++;
      if ({evt_valid, ack} !== 2'b10 || evt_data !== 32'h1234_5678)
        $display("FAIL bp_hold_%0d: got valid=%b ack=%b data=%h exp 1/0/12345678", i, evt_valid, ack, evt_data);
      else n_pass++;
      step(1);
    end
    evt_ready = 1'b1;
    step(1);
    n_total++; if ({evt_valid, ack} !== 2'b01) $display("FAIL bp_complete: got valid=%b ack=%b exp 0/1", evt_valid, ack); else n_pass++;
    n_total++; if (timeout_err !== 1'b0) $display("FAIL bp_no_err: got %b exp 0", timeout_err); else n_pass++;
    req_end();
  endtask

  task automatic test_timeout();
    evt_ready   = 1'b0;
    timeout_cfg = 16'd4;
    req_start(32'h0000_0044);
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if ({evt_valid, timeout_err, ack} !== 3'b100)
        $display("FAIL to_pend_%0d: got valid=%b err=%b ack=%b exp 1/0/0", i, evt_valid, timeout_err, ack);
      else n_pass++;
      step(1);
    end
    n_total++; if ({evt_valid, timeout_err, ack} !== 3'b011) $display("FAIL to_fire: got valid=%b err=%b ack=%b exp 0/1/1", evt_valid, timeout_err, ack); else n_pass++;
    n_total++; if (drop_cnt !== 8'd1) $display("FAIL to_drop_cnt: got %0d exp 1", drop_cnt); else n_pass++;
    req_end();
    n_total++; if (busy !== 1'b0) $display("FAIL to_idle: got busy=%b exp 0", busy); else n_pass++;
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    n_total++; if ({timeout_err, drop_cnt} !== 9'h0) $display("FAIL to_clear: got err=%b cnt=%0d exp 0/0", timeout_err, drop_cnt); else n_pass++;
    // evt_ready arrives exactly in the cycle the timeout would fire
    req_start(32'h0000_0055);
    step(3);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    n_total++; if ({evt_valid, ack, timeout_err} !== 3'b010 || drop_cnt !== 8'd0)
      $display("FAIL to_ready_wins: got valid=%b ack=%b err=%b cnt=%0d exp 0/1/0/0", evt_valid, ack, timeout_err, drop_cnt);
    else n_pass++;
    req_end();
  endtask

  task automatic test_cfg_change();
    evt_ready   = 1'b0;
    timeout_cfg = 16'd0;
    req_start(32'h0000_0066);
    step(5);
    timeout_cfg = 16'd7;
    n_total++; if (evt_valid !== 1'b1) $display("FAIL cfg_still_pend: got %b exp 1", evt_valid); else n_pass++;
    step(1);
    n_total++; if (evt_valid !== 1'b1) $display("FAIL cfg_fire_cycle: got %b exp 1", evt_valid); else n_pass++;
    step(1);
    n_total++; if ({evt_valid, timeout_err, ack} !== 3'b011 || drop_cnt !== 8'd1)
      $display("FAIL cfg_live_timeout: got valid=%b err=%b ack=%b cnt=%0d exp 0/1/1/1", evt_valid, timeout_err, ack, drop_cnt);
    else n_pass++;
    req_end();
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
  endtask

  task automatic test_saturation();
    evt_ready   = 1'b0;
    timeout_cfg = 16'd1;
    for (int i = 0; i < 300; i++) begin
      req_start(i);
      step(1);
      req_end();
      if (i == 254) begin
        n_total++; if (drop_cnt !== 8'd255) $display("FAIL sat_reach: got %0d exp 255", drop_cnt); else n_pass++;
      end
    end
    n_total++; if ({timeout_err, drop_cnt} !== {1'b1, 8'd255}) $display("FAIL sat_hold: got err=%b cnt=%0d exp 1/255", timeout_err, drop_cnt); else n_pass++;
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    n_total++; if ({timeout_err, drop_cnt} !== 9'h0) $display("FAIL sat_clear: got err=%b cnt=%0d exp 0/0", timeout_err, drop_cnt); else n_pass++;
    // one drop so the counter is non-zero, then a clear coincident with a drop
    req_start(32'h0000_0077);
    step(1);
    req_end();
    req_start(32'h0000_0088);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    n_total++; if ({timeout_err, drop_cnt} !== {1'b1, 8'd1}) $display("FAIL sat_clr_vs_set: got err=%b cnt=%0d exp 1/1", timeout_err, drop_cnt); else n_pass++;
    req_end();
  endtask

  task automatic test_protocol();
    evt_ready   = 1'b1;
    timeout_cfg = 16'd0;
    req_start(32'h0000_0099);
    step(1);
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if ({evt_valid, ack} !== 2'b01)
        $display("FAIL proto_no_second_%0d: got valid=%b ack=%b exp 0/1", i, evt_valid, ack);
      else n_pass++;
      step(1);
    end
    req_end();
    n_total++; if ({ack, busy} !== 2'b00) $display("FAIL proto_release: got ack=%b busy=%b exp 0/0", ack, busy); else n_pass++;
    // asynchronous reset while an event is pending
    evt_ready = 1'b0;
    req_start(32'h0BAD_F00D);
    n_total++; if (evt_valid !== 1'b1) $display("FAIL proto_pend_before_rst: got %b exp 1", evt_valid); else n_pass++;
    #2;
    rst_n     = 1'b0;
    req_async = 1'b0;
    #1;
    n_total++; if ({ack, evt_valid, busy, timeout_err} !== 4'b0 || evt_data !== 32'h0 || drop_cnt !== 8'd0)
      $display("FAIL proto_async_rst: got ack=%b valid=%b busy=%b err=%b data=%h cnt=%0d exp all 0",
               ack, evt_valid, busy, timeout_err, evt_data, drop_cnt);
    else n_pass++;
    step(1);
    rst_n = 1'b1;
    step(4);
    n_total++; if ({ack, evt_valid, busy} !== 3'b000) $display("FAIL proto_after_rst: got ack=%b valid=%b busy=%b exp 0/0/0", ack, evt_valid, busy); else n_pass++;
  endtask

  initial begin
    n_pass      = 0;
    n_total     = 0;
    rst_n       = 1'b0;
    req_async   = 1'b0;
    req_data    = 32'h0;
    evt_ready   = 1'b0;
    timeout_cfg = 16'd0;
    err_clr     = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_cfg_change();
    test_saturation();
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pulse_handshake_rsp.md
PULSE_HANDSHAKE_RSP -- requirements
Module: pulse_handshake_rsp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width.
REQ-002 SHALL have parameter SYNC_STEP, default 2, request synchronizer depth (min 2).
REQ-003 SHALL have parameter TO_W, default 16, timeout counter width.
REQ-004 SHALL have port clk  input  1  single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port req_async  input  1  level request from the remote domain, unsynchronized.
REQ-007 SHALL have port req_data  input  DATA_W  payload, held stable by the remote while req_async is high.
REQ-008 SHALL have port ack  output  1  registered level acknowledge back to the remote domain.
REQ-009 SHALL have port evt_valid  output  1  local event valid.
REQ-010 SHALL have port evt_data  output  DATA_W  captured payload.
REQ-011 SHALL have port evt_ready  input  1  local consumer accept.
REQ-012 SHALL have port timeout_cfg  input  TO_W  maximum PEND cycles; 0 disables the timeout.
REQ-013 SHALL have port timeout_err  output  1  sticky timeout flag.
REQ-014 SHALL have port err_clr  input  1  single-cycle clear for timeout_err and drop_cnt.
REQ-015 SHALL have port drop_cnt  output  8  saturating count of dropped events.
REQ-016 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-017 SHALL pass req_async through a SYNC_STEP-stage synchronizer to produce req_s; no other logic SHALL sample req_async.
REQ-018 SHALL implement the states IDLE, PEND and ACKH.
REQ-019 In IDLE with req_s=1, the block SHALL capture req_data into evt_data and enter PEND.
REQ-020 evt_valid SHALL be high exactly while in PEND, so it rises SYNC_STEP+1 rising edges after req_async rises.
REQ-021 In PEND with evt_ready=1, the event SHALL complete: next state ACKH and ack=1 from the next cycle.
REQ-022 evt_data SHALL remain stable throughout PEND.
REQ-023 In ACKH with req_s=0, the block SHALL return to IDLE and deassert ack on the same edge.
REQ-024 In ACKH with req_s=1, the block SHALL hold ack=1 and SHALL NOT raise a new event.
REQ-025 A new request SHALL be accepted only after returning to IDLE (4-phase protocol).
REQ-026 The PEND counter SHALL clear on entry to PEND and increment every PEND cycle.
REQ-027 When timeout_cfg≠0 and the counter equals timeout_cfg-1 without evt_ready, the block SHALL:
- drop the event: evt_valid low next cycle;
- set timeout_err;
- increment drop_cnt, saturating at 255;
- assert ack and enter ACKH, so the remote is never deadlocked.
REQ-028 If evt_ready and the timeout fire in the same cycle, evt_ready SHALL win: no drop and no error.
REQ-029 When err_clr=1, timeout_err SHALL clear and drop_cnt SHALL reset to 0.
REQ-030 If err_clr and a new timeout occur in the same cycle, the set SHALL win: timeout_err=1 and drop_cnt=1.
REQ-031 The counter SHALL saturate and never wrap.
REQ-032 A change of timeout_cfg during PEND SHALL take effect immediately.

Reset
REQ-033 When rst_n is low, the block SHALL force:
- state IDLE;
- ack=0, evt_valid=0, evt_data=0;
- timeout_err=0, drop_cnt=0;
- counter=0;
- synchronizer flops=0.
REQ-034 Reset mid-operation SHALL abandon the event without acknowledgement; the remote side SHALL be reset together with this block.

Structure
REQ-035 The state encoding and the drop_cnt saturation constant SHALL be defined in the shared common_ip package.
REQ-036 The synchronizer SHALL be one instance of jlsemi_util_sync_pos_with_rst_low with SYNC_STEP passed through.

Verification
REQ-037 Basic handshake: req_async↑ with req_data=0xA5A5_0001 and evt_ready tied to 1 -> evt_valid for 1 cycle at edge 3, evt_data=0xA5A5_0001, then ack=1, and ack=0 three edges after req_async↓.
REQ-038 Backpressure: evt_ready held low for 10 cycles with timeout_cfg=0 -> evt_valid held for 10 cycles, evt_data stable, ack=0 until evt_ready=1.
REQ-039 Timeout: timeout_cfg=4 and evt_ready held low -> evt_valid for 4 cycles, timeout_err=1, drop_cnt=1, ack=1; on the same cycle as a timeout, evt_ready=1 -> no error.
REQ-040 Saturation and clear: 300 consecutive timeouts -> drop_cnt=255; then err_clr -> timeout_err=0 and drop_cnt=0; err_clr coincident with a timeout -> timeout_err=1 and drop_cnt=1.
REQ-041 Protocol: req_async held high after ack -> no second event; rst_n pulsed low in PEND -> all outputs at reset values within the same cycle.
